olive_std_core_led_seq: RTL

Avalon-MM programmable LED sequencer that generates the single-bit LED drive for the board's status LED. It replaces the plain LED PIO output with a hardware-timed source. Software selects one of four modes: manual level, blink, 16-step pattern, or hardware-activity indication with pulse stretching. The block sits on the Avalon bus beside the other olive_std_core peripherals, and its `led_out` goes straight to the LED pin.

---
 rtl/olive_std_core_led_seq.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/olive_std_core_led_seq.sv
// olive_std_core_led_seq
// Avalon-MM programmable LED sequencer driving the single status LED.
// Modes: manual level, blink, 16-step pattern, hardware-activity indication
// with pulse stretching.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   address     register select (0 CTRL, 1 PRESCALE, 2 PATTERN, 3 STATUS)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read of the addressed register
//   act_pulse   activity request, any high cycle is an event
//   led_out     registered LED drive
module olive_std_core_led_seq #(
    parameter logic [23:0] PRESCALE_RESET = 24'd4999999,
    parameter int unsigned STRETCH_TICKS  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        act_pulse,
    output logic        led_out
);

    localparam logic [1:0] ModeManual  = 2'd0;
    localparam logic [1:0] ModeBlink   = 2'd1;
    localparam logic [1:0] ModePattern = 2'd2;
    localparam logic [1:0] ModeAct     = 2'd3;

    localparam logic [3:0] StretchLen = 4'(STRETCH_TICKS);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } act_state_e;

    // Register file
    logic [1:0]  mode_q, mode_d;
    logic        level_q, level_d;
    logic [23:0] prescale_q, prescale_d;
    logic [15:0] bits_q, bits_d;
    logic [3:0]  len_q, len_d;

    // Sequencer state
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  step_q, step_d;
    logic        phase_q, phase_d;
    act_state_e  state_q, state_d;
    logic [3:0]  tcnt_q, tcnt_d;
    logic        pend_q, pend_d;
    logic        led_q, led_d;

    logic        wr;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_pattern;
    logic        restart;
    logic        tick;
    logic [3:0]  tcnt_inc;

    logic        unused_wdata;
    assign unused_wdata = ^writedata[31:24];

    assign wr          = chipselect & ~write_n;
    assign wr_ctrl     = wr & (address == 2'd0);
    assign wr_prescale = wr & (address == 2'd1);
    assign wr_pattern  = wr & (address == 2'd2);
    assign restart     = (wr & (address == 2'd3) & writedata[0])
                       | (wr_ctrl & (writedata[1:0] != mode_q));
    assign tick        = (cnt_q == prescale_q);
    assign tcnt_inc    = tcnt_q + 4'd1;

    // Register writes
    always_comb begin
        mode_d     = mode_q;
        level_d    = level_q;
        prescale_d = prescale_q;
        bits_d     = bits_q;
        len_d      = len_q;
        if (wr_ctrl) begin
            mode_d  = writedata[1:0];
            level_d = writedata[8];
        end
        if (wr_prescale) begin
            prescale_d = writedata[23:0];
        end
        if (wr_pattern) begin
            bits_d = writedata[15:0];
            len_d  = writedata[19:16];
        end
    end

    // Prescaler, blink phase, pattern step and activity FSM
    always_comb begin
        cnt_d   = cnt_q;
        step_d  = step_q;
        phase_d = phase_q;
        state_d = state_q;
        tcnt_d  = tcnt_q;
        pend_d  = pend_q;
        if (restart) begin
            // Restart swallows any tick and act_pulse of this cycle.
            cnt_d   = '0;
            step_d  = '0;
            phase_d = 1'b0;
            state_d = StIdle;
            tcnt_d  = '0;
            pend_d  = 1'b0;
        end else begin
            if (wr_prescale || tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 24'd1;
            end
            if (tick && (mode_q == ModeBlink)) begin
                phase_d = ~phase_q;
            end
            if (tick && (mode_q == ModePattern)) begin
                // >= so a shortened LEN below the current step wraps on the next tick.
                step_d = (step_q >= len_q) ? 4'd0 : step_q + 4'd1;
            end
            if (mode_q != ModeAct) begin
                state_d = StIdle;
                tcnt_d  = '0;
                pend_d  = 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (act_pulse) begin
                            state_d = StOn;
                            tcnt_d  = '0;
                        end
                    end
                    StOn: begin
                        if (act_pulse) begin
                            pend_d = 1'b1;
                        end
                        if (tick) begin
                            tcnt_d = tcnt_inc;
                            if (tcnt_inc == StretchLen) begin
                                state_d = StGap;
                            end
                        end
                    end
                    StGap: begin
                        if (tick) begin
                            if (pend_q || act_pulse) begin
                                state_d = StOn;
                                tcnt_d  = '0;
                                pend_d  = 1'b0;
                            end else begin
                                state_d = StIdle;
                            end
                        end else if (act_pulse) begin
                            pend_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end
    end

    // LED is derived from the current state, hence one cycle behind it.
    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            ModeManual:  led_d = level_q;
            ModeBlink:   led_d = phase_q;
            ModePattern: led_d = bits_q[step_q];
            ModeAct:     led_d = (state_q == StOn);
            default:     led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q     <= ModeManual;
            level_q    <= 1'b0;
            prescale_q <= PRESCALE_RESET;
            bits_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            step_q     <= '0;
            phase_q    <= 1'b0;
            state_q    <= StIdle;
            tcnt_q     <= '0;
            pend_q     <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            level_q    <= level_d;
            prescale_q <= prescale_d;
            bits_q     <= bits_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            phase_q    <= phase_d;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            pend_q     <= pend_d;
            led_q      <= led_d;
        end
    end

    assign led_out = led_q;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[1:0] = mode_q;
                readdata[8]   = level_q;
            end
            2'd1: readdata[23:0] = prescale_q;
            2'd2: begin
                readdata[15:0]  = bits_q;
                readdata[19:16] = len_q;
            end
            default: begin
                readdata[0]   = led_q;
                readdata[7:4] = step_q;
                readdata[9:8] = state_q;
            end
        endcase
    end

endmodule
